ppm_multi_out: RTL

- Parametrised multi-channel PPM/servo pulse generator on the CPU data bus.
- Successor to the fixed four-instance per-engine PPM scheme: one block drives `CHANNELS` outputs from a single CPU clock.
- Provides double-buffered per-channel values, an atomic commit, an output enable and an optional failsafe watchdog.
- Sits behind the bus controller; its `PPM` pins drive the ESCs.

---
 rtl/ppm_multi_out_if.sv | 9 +
 rtl/ppm_multi_out.sv | 103 ++++++++++
 2 files changed

// File: rtl/ppm_multi_out_if.sv
// ppm_multi_out_if: CPU register bus between the bus controller and the PPM generator.
interface ppm_multi_out_if;
    logic        WE;
    logic [3:0]  ADDR;
    logic [31:0] WD;
    logic [31:0] RD;
    modport master (output WE, ADDR, WD, input RD);
    modport slave (input WE, ADDR, WD, output RD);
endinterface

// File: rtl/ppm_multi_out.sv
// ppm_multi_out: multi-channel PPM/servo generator with double-buffered values and atomic commit.
// Optional failsafe watchdog enabled by defining PPM_FAILSAFE_EN.
module ppm_multi_out #(
    parameter int CHANNELS   = 4,
    parameter int VAL_W      = 10,
    parameter int CLK_DIV    = 50,
    parameter int FRAME_US   = 20000,
    parameter int MIN_US     = 1000,
    parameter int MAX_VAL    = 1000,
    parameter int WDT_FRAMES = 25
) (
    input  logic                CLK,
    input  logic                RESET,
    ppm_multi_out_if.slave      bus,
    output logic [CHANNELS-1:0] PPM,
    output logic                FRAME_START
);
    localparam int PSC_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [PSC_W-1:0] psc;
    logic [15:0]      frame_cnt;
    logic [VAL_W-1:0] shadow [CHANNELS];
    logic [VAL_W-1:0] active [CHANNELS];
    logic [VAL_W-1:0] wval;
    logic             pending, enable, failsafe, trip, tick, ctrl_we;

    assign tick        = psc == PSC_W'(CLK_DIV - 1);
    assign FRAME_START = tick && frame_cnt == 16'(FRAME_US - 1);
    assign ctrl_we     = bus.WE && bus.ADDR == 4'(CHANNELS);
    assign wval        = bus.WD[VAL_W-1:0] > VAL_W'(MAX_VAL) ? VAL_W'(MAX_VAL) : bus.WD[VAL_W-1:0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            psc       <= '0;
            frame_cnt <= '0;
        end else begin
            psc <= tick ? '0 : psc + 1'b1;
            if (tick) frame_cnt <= FRAME_START ? '0 : frame_cnt + 16'd1;
        end
    end

    // A commit write in the load cycle wins, so the load repeats next frame
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pending <= 1'b0;
            enable  <= 1'b0;
        end else begin
            if (ctrl_we) enable <= bus.WD[1];
            pending <= (ctrl_we && bus.WD[0]) || (pending && !FRAME_START);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.WE && bus.ADDR == 4'(i)) shadow[i] <= wval;
                if (FRAME_START && pending) active[i] <= shadow[i];
                else if (trip) active[i] <= '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) PPM <= '0;
        else
            for (int i = 0; i < CHANNELS; i++)
                PPM[i] <= enable && 17'(frame_cnt) < 17'(MIN_US) + 17'(active[i]);
    end

`ifdef PPM_FAILSAFE_EN
    logic [15:0] wdt;
    assign trip = FRAME_START && !pending && 17'(wdt) + 17'd1 >= 17'(WDT_FRAMES);
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wdt      <= '0;
            failsafe <= 1'b0;
        end else if (FRAME_START) begin
            if (pending) begin
                wdt      <= '0;
                failsafe <= 1'b0;
            end else begin
                if (wdt != 16'hFFFF) wdt <= wdt + 16'd1;
                if (trip) failsafe <= 1'b1;
            end
        end
    end
`else
    // No watchdog: failsafe is a constant 0 that still ties off the timeout parameter
    assign trip     = 1'b0;
    assign failsafe = WDT_FRAMES < 0;
`endif

    always_comb begin
        bus.RD = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (bus.ADDR == 4'(i)) bus.RD = 32'(shadow[i]);
        if (bus.ADDR == 4'(CHANNELS)) bus.RD = {frame_cnt, 13'b0, failsafe, enable, pending};
    end
endmodule
